// File: rtl/shift_register_right5_circular.sv
// Circular right-rotate register with a synchronous parallel preset load.
// Used as a ring counter or rotating pattern source, with true and complemented outputs.
module shift_register_right5_circular #(
  parameter int WIDTH = 5
) (
  input  logic             clockpulse,
  input  logic             clear,
  input  logic             preset_enable,
  input  logic [WIDTH-1:0] preset,
  output logic [WIDTH-1:0] signal_q,
  output logic [WIDTH-1:0] signal_q_
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  // Load has priority over rotate; there is no hold mode.
  always_comb begin
    shift_d = {shift_q[0], shift_q[WIDTH-1:1]};
    if (preset_enable) begin
      shift_d = preset;
    end
  end

  always_ff @(posedge clockpulse or negedge clear) begin
    if (!clear) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign signal_q  = shift_q;
  assign signal_q_ = ~shift_q;

endmodule

// File: tb/tb_shift_register_right5_circular.sv
// Directed bench for shift_register_right5_circular.
// Expected values are queued when stimulus is applied and popped when the output is sampled.
module tb_shift_register_right5_circular;

  logic       clockpulse;
  logic       clear;
  logic       preset_enable;
  logic [4:0] preset;
  logic [4:0] signal_q;
  logic [4:0] signal_q_;

  int checks = 0;
  int errors = 0;
  logic [4:0] model;
  logic [4:0] sb[$];

  shift_register_right5_circular #(.WIDTH(5)) dut (
    .clockpulse   (clockpulse),
    .clear        (clear),
    .preset_enable(preset_enable),
    .preset       (preset),
    .signal_q     (signal_q),
    .signal_q_    (signal_q_)
  );

  initial clockpulse = 1'b0;
  always #5 clockpulse = ~clockpulse;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag);
    logic [4:0] exp;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      exp = sb.pop_front();
      assert (signal_q === exp) else begin
        errors++;
        $error("FAIL %s signal_q observed=%b expected=%b", tag, signal_q, exp);
      end
      checks++;
      assert (signal_q_ === ~exp) else begin
        errors++;
        $error("FAIL %s signal_q_ observed=%b expected=%b", tag, signal_q_, ~exp);
      end
    end
  endtask

  // Advance the reference model for one rising edge.
  task automatic model_edge();
    if (!clear) model = 5'b00000;
    else if (preset_enable) model = preset;
    else model = (model >> 1) | (model[0] ? 5'b10000 : 5'b00000);
  endtask

  task automatic step(input string tag);
    model_edge();
    sb.push_back(model);
    @(posedge clockpulse);
    #1;
    check(tag);
  endtask

  // Rotate edge whose expected value comes from a fixed table.
  task automatic step_exp(input string tag, input logic [4:0] exp);
    sb.push_back(exp);
    model = exp;
    @(posedge clockpulse);
    #1;
    check(tag);
  endtask

  initial begin
    logic [4:0] seq [5];
    seq[0] = 5'b01100; seq[1] = 5'b00110; seq[2] = 5'b00011;
    seq[3] = 5'b10001; seq[4] = 5'b11000;

    // Reset held with load requested: clock and preset are ignored.
    clear = 1'b0; preset_enable = 1'b1; preset = 5'b11000;
    model = 5'b00000;
    #2;
    sb.push_back(model);
    check("reset_async");
    for (int i = 0; i < 3; i++) step("reset_hold");

    // Release between edges causes no change by itself.
    clear = 1'b1;
    #2;
    sb.push_back(model);
    check("release_no_change");

    step("load_11000");

    preset_enable = 1'b0;
    for (int i = 0; i < 5; i++) step_exp("rotate_seq", seq[i]);
    for (int i = 0; i < 14; i++) step_exp("rotate_period", seq[i % 5]);

    // LSB wraps into MSB.
    preset_enable = 1'b1; preset = 5'b00001;
    step("load_00001");
    preset_enable = 1'b0;
    step_exp("wrap_lsb_msb", 5'b10000);

    // All-ones is a fixed point.
    preset_enable = 1'b1; preset = 5'b11111;
    step("load_11111");
    preset_enable = 1'b0;
    for (int i = 0; i < 4; i++) step_exp("ones_fixed", 5'b11111);

    // Mid-rotation reset between edges.
    preset_enable = 1'b1; preset = 5'b10110;
    step("load_10110");
    preset_enable = 1'b0;
    step("rotate_pre_reset");
    #2;
    clear = 1'b0;
    #1;
    model = 5'b00000;
    sb.push_back(model);
    check("reset_mid_rotation");
    step("reset_mid_hold");
    clear = 1'b1;
    for (int i = 0; i < 3; i++) step("zero_fixed");

    // Held load keeps output at preset.
    preset_enable = 1'b1; preset = 5'b10100;
    for (int i = 0; i < 3; i++) step("hold_load_10100");
    #1;
    preset = 5'b01011;
    #2;
    sb.push_back(model);
    check("preset_change_between_edges");
    step("load_01011");

    // Load then rotate from a fresh random pattern, checked against the model.
    preset = 5'($urandom_range(0, 31));
    step("load_random");
    preset_enable = 1'b0;
    for (int i = 0; i < 6; i++) step("rotate_random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
